// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// address-split widths, FSM state encoding and address-field extraction.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_READY  = 2'd1,
        ST_REFILL = 2'd2,
        ST_REPLAY = 2'd3
    } state_e;

    function automatic int off_w_f(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w_f(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Two low address bits select a byte inside a 32-bit word and are never used.
    function automatic int tag_w_f(input int addr_w, input int num_lines, input int line_words);
        return addr_w - idx_w_f(num_lines) - off_w_f(line_words) - 2;
    endfunction

    // Returns addr[lsb +: width], zero-extended to 64 bits.
    function automatic logic [63:0] addr_field_f(input logic [63:0] addr, input int lsb, input int width);
        logic [63:0] mask_s;
        mask_s = (64'd1 << width) - 64'd1;
        return (addr >> lsb) & mask_s;
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register resets to zero and can be cleared synchronously.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_wr_en,
    input  logic [AW-1:0]    I_wr_addr,
    input  logic [WIDTH-1:0] I_wr_data,
    input  logic             I_rd_en,
    input  logic             I_rd_clr,
    input  logic [AW-1:0]    I_rd_addr,
    output logic [WIDTH-1:0] O_rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Write port; the array itself carries no reset so it maps onto block RAM.
    always_ff @(posedge I_clk) begin
        if (I_wr_en) begin
            mem_r[I_wr_addr] <= I_wr_data;
        end
    end

    // Registered read port; holds its value when neither read nor clear is requested.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (I_rd_clr) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (I_rd_en) begin
            rd_data_r <= mem_r[I_rd_addr];
        end
    end

    assign O_rd_data = rd_data_r;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with on-demand burst refill and whole-cache flush.
// Tags and valid bits live in flops; instruction words live in icache_data_ram.
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic              I_flush,
    output logic [31:0]       O_data,
    output logic              O_stall,
    output logic              O_mem_req,
    output logic [ADDR_W-1:0] O_mem_addr,
    input  logic              I_mem_valid,
    input  logic [31:0]       I_mem_data
);

    localparam int OFF_W  = off_w_f(LINE_WORDS);
    localparam int IDX_W  = idx_w_f(NUM_LINES);
    localparam int TAG_W  = tag_w_f(ADDR_W, NUM_LINES, LINE_WORDS);
    localparam int RAM_AW = IDX_W + OFF_W;

    state_e             state_r;
    state_e             state_nxt_s;

    logic [63:0]        addr64_s;
    logic [63:0]        off64_s;
    logic [63:0]        idx64_s;
    logic [63:0]        tag64_s;
    logic [OFF_W-1:0]   off_s;
    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               unused_s;

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_arr_r [NUM_LINES];
    logic [TAG_W-1:0]   miss_tag_r;
    logic [IDX_W-1:0]   miss_idx_r;
    logic [OFF_W-1:0]   beat_cnt_r;
    logic [IDX_W-1:0]   flush_cnt_r;
    logic               pend_r;
    logic               stall_r;
    logic               mem_req_r;
    logic [ADDR_W-1:0]  mem_addr_r;

    logic               hit_s;
    logic               rd_en_s;
    logic               miss_s;
    logic               beat_s;
    logic               last_s;

    assign addr64_s = 64'(I_addr);
    assign off64_s  = addr_field_f(addr64_s, 2, OFF_W);
    assign idx64_s  = addr_field_f(addr64_s, OFF_W + 2, IDX_W);
    assign tag64_s  = addr_field_f(addr64_s, OFF_W + IDX_W + 2, TAG_W);
    assign off_s    = off64_s[OFF_W-1:0];
    assign idx_s    = idx64_s[IDX_W-1:0];
    assign tag_s    = tag64_s[TAG_W-1:0];
    assign unused_s = ^{off64_s[63:OFF_W], idx64_s[63:IDX_W], tag64_s[63:TAG_W], I_addr[1:0]};

    // A flush in READY discards the lookup, so it suppresses both hit and miss handling.
    assign hit_s   = valid_r[idx_s] && (tag_arr_r[idx_s] == tag_s);
    assign rd_en_s = (state_r == ST_READY) && !I_flush && hit_s;
    assign miss_s  = (state_r == ST_READY) && !I_flush && !hit_s;
    assign beat_s  = (state_r == ST_REFILL) && I_mem_valid;
    assign last_s  = beat_s && (&beat_cnt_r);

    // FSM state register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r <= ST_FLUSH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FLUSH: begin
                if (&flush_cnt_r) state_nxt_s = ST_READY;
                else              state_nxt_s = ST_FLUSH;
            end
            ST_READY: begin
                if (I_flush)    state_nxt_s = ST_FLUSH;
                else if (hit_s) state_nxt_s = ST_READY;
                else            state_nxt_s = ST_REFILL;
            end
            ST_REFILL: begin
                if (last_s) state_nxt_s = ST_REPLAY;
                else        state_nxt_s = ST_REFILL;
            end
            ST_REPLAY: begin
                if (pend_r || I_flush) state_nxt_s = ST_FLUSH;
                else                   state_nxt_s = ST_READY;
            end
            default: state_nxt_s = ST_FLUSH;
        endcase
    end

    // Stall, refill request and the line address latched at the miss.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            stall_r    <= 1'b1;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            miss_tag_r <= {TAG_W{1'b0}};
            miss_idx_r <= {IDX_W{1'b0}};
        end else begin
            stall_r <= !rd_en_s;
            if (miss_s) begin
                mem_req_r  <= 1'b1;
                mem_addr_r <= {tag_s, idx_s, {(OFF_W + 2){1'b0}}};
                miss_tag_r <= tag_s;
                miss_idx_r <= idx_s;
            end else if (last_s) begin
                mem_req_r <= 1'b0;
            end
        end
    end

    // Beat and flush-sweep counters; both wrap to zero at the end of their run.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            beat_cnt_r  <= {OFF_W{1'b0}};
            flush_cnt_r <= {IDX_W{1'b0}};
        end else begin
            if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + OFF_W'(1);
            end
            if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + IDX_W'(1);
            end
        end
    end

    // A flush seen mid-refill is remembered until the sweep actually starts.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pend_r <= 1'b0;
        end else if (state_nxt_s == ST_FLUSH) begin
            pend_r <= 1'b0;
        end else if (I_flush && ((state_r == ST_REFILL) || (state_r == ST_REPLAY))) begin
            pend_r <= 1'b1;
        end
    end

    // Valid bits: swept clear one per cycle in FLUSH, set when a line fill completes.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (state_r == ST_FLUSH) begin
            valid_r[flush_cnt_r] <= 1'b0;
        end else if (last_s) begin
            valid_r[miss_idx_r] <= 1'b1;
        end
    end

    // Tag array; only meaningful where the matching valid bit is set.
    always_ff @(posedge I_clk) begin
        if (last_s) begin
            tag_arr_r[miss_idx_r] <= miss_tag_r;
        end
    end

    icache_data_ram #(
        .DEPTH (NUM_LINES * LINE_WORDS),
        .WIDTH (32),
        .AW    (RAM_AW)
    ) u_data_ram (
        .I_clk     (I_clk),
        .I_rst_n   (I_rst_n),
        .I_wr_en   (beat_s),
        .I_wr_addr ({miss_idx_r, beat_cnt_r}),
        .I_wr_data (I_mem_data),
        .I_rd_en   (rd_en_s),
        .I_rd_clr  (state_r == ST_FLUSH),
        .I_rd_addr ({idx_s, off_s}),
        .O_rd_data (O_data)
    );

    assign O_stall    = stall_r;
    assign O_mem_req  = mem_req_r;
    assign O_mem_addr = mem_addr_r;

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_icache_dm;

    logic        I_clk;
    logic        I_rst_n;
    logic [31:0] I_addr;
    logic        I_flush;
    logic [31:0] O_data;
    logic        O_stall;
    logic        O_mem_req;
    logic [31:0] O_mem_addr;
    logic        I_mem_valid;
    logic [31:0] I_mem_data;

    int total;
    int bad;

    icache_dm dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_addr      (I_addr),
        .I_flush     (I_flush),
        .O_data      (O_data),
        .O_stall     (O_stall),
        .O_mem_req   (O_mem_req),
        .O_mem_addr  (O_mem_addr),
        .I_mem_valid (I_mem_valid),
        .I_mem_data  (I_mem_data)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic tick();
        @(negedge I_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for O_mem_req to rise; checks the cycle count and that O_stall stayed high.
    task automatic wait_req(input string tag, input int exp_n);
        int   n;
        logic stall_ok;
        n = 0;
        stall_ok = 1'b1;
        do begin
            tick();
            n++;
            if (O_stall !== 1'b1) stall_ok = 1'b0;
        end while (O_mem_req !== 1'b1 && n < 200);
        chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, "_stall_held"}, {31'd0, stall_ok}, 32'd1);
    endtask

    // Supplies four beats base+0..base+3 with `gap` idle cycles between them.
    task automatic feed(input logic [31:0] base, input int gap);
        for (int k = 0; k < 4; k++) begin
            I_mem_valid = 1'b1;
            I_mem_data  = base + 32'(k);
            tick();
            I_mem_valid = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("req_in_gap", {31'd0, O_mem_req}, 32'd1);
                end
            end
        end
    endtask

    // After the last beat: request drops, one more stall cycle, then the word appears.
    task automatic expect_word(input string tag, input logic [31:0] exp);
        chk({tag, "_req_drop"}, {31'd0, O_mem_req}, 32'd0);
        tick();
        chk({tag, "_replay_stall"}, {31'd0, O_stall}, 32'd1);
        tick();
        chk({tag, "_stall"}, {31'd0, O_stall}, 32'd0);
        chk({tag, "_data"}, O_data, exp);
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
        I_addr = addr;
        tick();
        chk("hit_stall", {31'd0, O_stall}, 32'd0);
        chk("hit_data", O_data, exp);
    endtask

    task automatic fetch_miss(input logic [31:0] addr);
        I_addr = addr;
        tick();
        chk("miss_stall", {31'd0, O_stall}, 32'd1);
        chk("miss_req", {31'd0, O_mem_req}, 32'd1);
        chk("miss_maddr", O_mem_addr, addr & ~32'h0000_000F);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        I_rst_n     = 1'b0;
        I_flush     = 1'b0;
        I_mem_valid = 1'b0;
        I_mem_data  = 32'd0;
        I_addr      = 32'h0000_0100;

        // Reset values, then a 64-cycle sweep before the first miss is seen.
        tick();
        tick();
        chk("reset_stall", {31'd0, O_stall}, 32'd1);
        chk("reset_data", O_data, 32'd0);
        chk("reset_req", {31'd0, O_mem_req}, 32'd0);
        chk("reset_maddr", O_mem_addr, 32'd0);
        I_rst_n = 1'b1;
        wait_req("boot", 65);
        chk("boot_maddr", O_mem_addr, 32'h0000_0100);

        // Cold miss, back-to-back beats, then sequential hits.
        feed(32'h0000_00A0, 0);
        expect_word("cold", 32'h0000_00A0);
        fetch_hit(32'h0000_0104, 32'h0000_00A1);
        fetch_hit(32'h0000_0108, 32'h0000_00A2);
        fetch_hit(32'h0000_010C, 32'h0000_00A3);

        // Refill with two idle cycles between beats.
        fetch_miss(32'h0000_0300);
        feed(32'h0000_00B0, 2);
        expect_word("gap", 32'h0000_00B0);
        fetch_hit(32'h0000_0308, 32'h0000_00B2);

        // Conflict on index 16: 0x500 evicts 0x100.
        fetch_hit(32'h0000_0100, 32'h0000_00A0);
        fetch_miss(32'h0000_0500);
        feed(32'h0000_00D0, 0);
        expect_word("conflict", 32'h0000_00D0);
        fetch_hit(32'h0000_050C, 32'h0000_00D3);
        fetch_miss(32'h0000_0100);
        feed(32'h0000_00A0, 0);
        expect_word("evicted", 32'h0000_00A0);

        // Flush pulse mid-refill: burst completes, then a full sweep, then a fresh miss.
        fetch_miss(32'h0000_0200);
        I_mem_valid = 1'b1;
        I_mem_data  = 32'h0000_00C0;
        tick();
        I_mem_valid = 1'b0;
        I_flush     = 1'b1;
        tick();
        chk("flush_req_held", {31'd0, O_mem_req}, 32'd1);
        I_flush = 1'b0;
        for (int k = 1; k < 4; k++) begin
            I_mem_valid = 1'b1;
            I_mem_data  = 32'h0000_00C0 + 32'(k);
            tick();
        end
        I_mem_valid = 1'b0;
        chk("flush_req_drop", {31'd0, O_mem_req}, 32'd0);
        wait_req("flush", 66);
        chk("flush_maddr", O_mem_addr, 32'h0000_0200);

        // Reset after two beats: request and stall react without a clock edge.
        I_mem_valid = 1'b1;
        I_mem_data  = 32'h0000_00E0;
        tick();
        I_mem_data  = 32'h0000_00E1;
        tick();
        I_mem_valid = 1'b0;
        I_rst_n     = 1'b0;
        #1;
        chk("rst_req", {31'd0, O_mem_req}, 32'd0);
        chk("rst_stall", {31'd0, O_stall}, 32'd1);
        chk("rst_data", O_data, 32'd0);
        tick();
        I_rst_n = 1'b1;
        wait_req("rst", 65);
        chk("rst_maddr", O_mem_addr, 32'h0000_0200);
        feed(32'h0000_00F0, 0);
        expect_word("post_rst", 32'h0000_00F0);
        fetch_hit(32'h0000_0204, 32'h0000_00F1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
